framebuffer_scanout_reader: RTL and testbench

- Read-side master for the shared 128-bit byte-addressed data RAM. The CPU writes through port a; this block drives read-only port b to stream a framebuffer to the HDMI pixel pipeline.
- Issues aligned 16-byte word reads over a contiguous frame region and absorbs the RAM's 1-cycle read latency in a small word FIFO.
- Unpacks each word into 8-bit pixels on a valid/ready stream, with start-of-frame and end-of-frame markers.

---
 rtl/scanout_pkg.sv | 19 +
 rtl/scanout_word_fifo.sv | 67 ++++++
 rtl/framebuffer_scanout_reader.sv | 154 +++++++++++++++
 tb/tb_framebuffer_scanout_reader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanout_pkg.sv
// Shared widths, state encoding and address helper for the framebuffer scanout reader.
package scanout_pkg;

  localparam int ADDR_W         = 19;
  localparam int DATA_W         = 128;
  localparam int BYTES_PER_WORD = 16;
  localparam int OFFSET_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/scanout_word_fifo.sv
// Show-ahead word FIFO absorbing the RAM read latency; flush empties it in one cycle.
module scanout_word_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 128,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/framebuffer_scanout_reader.sv
// Streams a framebuffer region from RAM port b as 8-bit pixels with frame markers,
// issuing word reads under FIFO credit and unpacking words little-endian.
module framebuffer_scanout_reader
  import scanout_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 19'h00000,
  parameter int                FRAME_BYTES = 307200,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_out_b,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_sof,
  output logic              pixel_last,
  output logic              busy
);

  localparam int NWORDS = FRAME_BYTES / BYTES_PER_WORD;
  localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NWORDS - 1);

  state_t              state_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                inflight_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WORD_W-1:0]   issue_idx_reg;
  logic [WORD_W-1:0]   pop_idx_reg;
  logic [OFFSET_W-1:0] byte_idx_reg;

  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_head;
  logic [CNT_W:0]      occupancy;
  logic                issue;
  logic                last_issue;
  logic                accept;
  logic                pop;
  logic                frame_done;

  // Credit counts words already buffered plus the one possibly still in the RAM pipe.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
  assign issue      = (state_reg == FETCH) && !frame_start && !fifo_full &&
                      (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign last_issue = issue && (issue_idx_reg == LAST_WORD);

  assign pixel_valid = !fifo_empty;
  assign pixel       = fifo_empty ? 8'h00 : fifo_head[{byte_idx_reg, 3'b000} +: 8];
  assign pixel_sof   = pixel_valid && (byte_idx_reg == '0) && (pop_idx_reg == '0);
  assign pixel_last  = pixel_valid && (byte_idx_reg == '1) && (pop_idx_reg == LAST_WORD);

  assign accept     = pixel_valid && pixel_ready;
  assign pop        = accept && (byte_idx_reg == '1);
  assign frame_done = accept && pixel_last;

  assign address_b = addr_reg;
  assign busy      = busy_reg;

  scanout_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) word_fifo (
    .clock (clock),
    .reset (reset),
    .flush (frame_start),
    .push  (inflight_reg),
    .pop   (pop),
    .din   (data_out_b),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      inflight_reg  <= 1'b0;
      addr_reg      <= BASE_ADDR;
      issue_idx_reg <= '0;
      pop_idx_reg   <= '0;
      byte_idx_reg  <= '0;
    end else begin
      inflight_reg <= issue;

      // The final issue parks the address at the base so it never walks past the region.
      if (issue) begin
        addr_reg      <= last_issue ? BASE_ADDR : next_word_addr(addr_reg);
        issue_idx_reg <= last_issue ? '0 : issue_idx_reg + 1'b1;
      end

      if (accept) begin
        byte_idx_reg <= byte_idx_reg + 1'b1;
        if (pop) begin
          pop_idx_reg <= (pop_idx_reg == LAST_WORD) ? '0 : pop_idx_reg + 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (enable && done_reg) begin
            state_reg <= FETCH;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        FETCH: begin
          if (last_issue) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (frame_done) begin
            if (enable) begin
              state_reg <= FETCH;
              addr_reg  <= BASE_ADDR;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      // Start or abort wins over every other transition; a read still in the pipe is dropped.
      if (frame_start) begin
        state_reg     <= FETCH;
        busy_reg      <= 1'b1;
        done_reg      <= 1'b0;
        inflight_reg  <= 1'b0;
        addr_reg      <= BASE_ADDR;
        issue_idx_reg <= '0;
        pop_idx_reg   <= '0;
        byte_idx_reg  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout_reader.sv
// Directed bench: two reader instances (low base and top-of-memory base) fed by RAM models.
module tb_framebuffer_scanout_reader;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         frame_start = 1'b0;
  logic         pixel_ready = 1'b0;
  logic [18:0]  address_b;
  logic [127:0] data_out_b;
  logic [7:0]   pixel;
  logic         pixel_valid, pixel_sof, pixel_last, busy;

  logic         enable_hi = 1'b0;
  logic         frame_start_hi = 1'b0;
  logic         ready_hi = 1'b0;
  logic [18:0]  address_b_hi;
  logic [127:0] data_hi;
  logic [7:0]   pixel_hi;
  logic         valid_hi, sof_hi, last_hi, busy_hi;

  int tests = 0;
  int fails = 0;

  logic [7:0]  got_pix[$];
  bit          got_sof[$];
  bit          got_last[$];
  logic [18:0] issued[$];
  int          max_occ;
  int          stall_bad;
  bit          busy_low;

  always #5 clock = ~clock;

  framebuffer_scanout_reader #(
    .BASE_ADDR(19'h00100), .FRAME_BYTES(64), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .frame_start(frame_start),
    .address_b(address_b), .data_out_b(data_out_b), .pixel(pixel),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_sof(pixel_sof),
    .pixel_last(pixel_last), .busy(busy)
  );

  framebuffer_scanout_reader #(
    .BASE_ADDR(19'h7FFC0), .FRAME_BYTES(64), .FIFO_DEPTH(4)
  ) dut_hi (
    .clock(clock), .reset(reset), .enable(enable_hi), .frame_start(frame_start_hi),
    .address_b(address_b_hi), .data_out_b(data_hi), .pixel(pixel_hi),
    .pixel_valid(valid_hi), .pixel_ready(ready_hi), .pixel_sof(sof_hi),
    .pixel_last(last_hi), .busy(busy_hi)
  );

  // RAM contents: byte at address A holds A[7:0]; one cycle read latency.
  function automatic logic [127:0] ram_word(input logic [18:0] a);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = a[7:0] + 8'(i);
    return w;
  endfunction

  always @(posedge clock) begin
    data_out_b <= ram_word(address_b);
    data_hi    <= ram_word(address_b_hi);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    got_pix.delete();
    got_sof.delete();
    got_last.delete();
    issued.delete();
    max_occ   = 0;
    stall_bad = 0;
    busy_low  = 0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Records accepted pixels, issued addresses and occupancy until n_lasts frame ends.
  task automatic collect(input int max_cycles, input int ready_pct, input int n_lasts,
                         output bit timed_out);
    int lasts = 0;
    int nissue = 0;
    int npop = 0;
    logic [18:0] prev_addr;
    bit prev_stall = 0;
    logic [7:0] prev_pix = '0;
    bit prev_sof = 0, prev_last = 0;
    prev_addr = address_b;
    timed_out = 1;
    for (int c = 0; c < max_cycles; c++) begin
      if (prev_stall && (!pixel_valid || pixel !== prev_pix ||
                         pixel_sof !== prev_sof || pixel_last !== prev_last))
        stall_bad++;
      pixel_ready = ($urandom_range(99) < ready_pct);
      prev_stall = pixel_valid && !pixel_ready;
      prev_pix = pixel;
      prev_sof = pixel_sof;
      prev_last = pixel_last;
      if (!busy) busy_low = 1;
      if (pixel_valid && pixel_ready) begin
        got_pix.push_back(pixel);
        got_sof.push_back(pixel_sof);
        got_last.push_back(pixel_last);
        if (got_pix.size() % 16 == 0) npop++;
        if (pixel_last) lasts++;
      end
      tick();
      if (address_b !== prev_addr) begin
        issued.push_back(prev_addr);
        nissue++;
        prev_addr = address_b;
      end
      if (nissue - npop > max_occ) max_occ = nissue - npop;
      if (lasts == n_lasts) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int changes = 0;
    logic [18:0] a0;
    tick();
    tests++;
    if (address_b !== 19'h00100 || pixel !== 8'h00 || pixel_valid !== 1'b0 ||
        pixel_sof !== 1'b0 || pixel_last !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: addr=%h pix=%h v=%b s=%b l=%b busy=%b, want 00100 00 0 0 0 0",
               address_b, pixel, pixel_valid, pixel_sof, pixel_last, busy);
    end
    tests++;
    if (address_b_hi !== 19'h7FFC0 || valid_hi !== 1'b0 || busy_hi !== 1'b0) begin
      fails++;
      $display("FAIL reset_values_hi: addr=%h v=%b busy=%b, want 7ffc0 0 0",
               address_b_hi, valid_hi, busy_hi);
    end
    reset = 1'b0;
    a0 = address_b;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (address_b !== a0 || busy || pixel_valid) changes++;
    end
    tests++;
    if (changes !== 0) begin
      fails++;
      $display("FAIL reset_idle_quiet: %0d active cycles, want 0", changes);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_basic();
    bit to;
    int bad = -1;
    clear_log();
    enable = 1'b0;
    pulse_start();
    collect(400, 100, 1, to);
    tests++;
    if (to) begin fails++; $display("FAIL basic_timeout: no pixel_last within 400 cycles, want one"); end
    tests++;
    if (got_pix.size() !== 64) begin
      fails++; $display("FAIL basic_count: got %0d pixels, want 64", got_pix.size());
    end
    foreach (got_pix[i])
      if (bad < 0 && (got_pix[i] !== 8'(i) || got_sof[i] !== (i == 0) || got_last[i] !== (i == 63)))
        bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL basic_pixels: idx %0d pix=%h sof=%b last=%b, want %h %b %b", bad,
               got_pix[bad], got_sof[bad], got_last[bad], 8'(bad), bad == 0, bad == 63);
    end
    tests++;
    if (issued.size() !== 4 || issued[0] !== 19'h00100 || issued[1] !== 19'h00110 ||
        issued[2] !== 19'h00120 || issued[3] !== 19'h00130) begin
      fails++;
      $display("FAIL basic_addr_seq: %0d issues first=%h, want 00100 00110 00120 00130",
               issued.size(), issued.size() > 0 ? issued[0] : 19'h0);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_drop: busy=%b after last, want 0", busy); end
    tests++;
    if (max_occ !== 4) begin fails++; $display("FAIL basic_occupancy: max %0d, want 4", max_occ); end
    $display("[TB] basic: %0d pixels, %0d issues", got_pix.size(), issued.size());
  endtask

  task automatic test_backpressure();
    bit to;
    int bad = -1;
    clear_log();
    pulse_start();
    collect(3000, 30, 1, to);
    tests++;
    if (to || got_pix.size() !== 64) begin
      fails++; $display("FAIL bp_count: got %0d pixels timeout=%b, want 64 0", got_pix.size(), to);
    end
    foreach (got_pix[i])
      if (bad < 0 && (got_pix[i] !== 8'(i) || got_sof[i] !== (i == 0) || got_last[i] !== (i == 63)))
        bad = i;
    tests++;
    if (bad >= 0) begin
      fails++; $display("FAIL bp_pixels: idx %0d pix=%h, want %h", bad, got_pix[bad], 8'(bad));
    end
    tests++;
    if (max_occ !== 4) begin fails++; $display("FAIL bp_credit: max occupancy %0d, want 4", max_occ); end
    tests++;
    if (stall_bad !== 0) begin fails++; $display("FAIL bp_stall_hold: %0d unstable stalls, want 0", stall_bad); end
    $display("[TB] backpressure: %0d pixels, max occupancy %0d", got_pix.size(), max_occ);
  endtask

  task automatic test_continuous();
    bit to;
    int bad = -1;
    int abad = -1;
    clear_log();
    enable = 1'b1;
    pulse_start();
    collect(2000, 100, 3, to);
    tests++;
    if (to || got_pix.size() !== 192) begin
      fails++; $display("FAIL cont_count: got %0d pixels timeout=%b, want 192 0", got_pix.size(), to);
    end
    foreach (got_pix[i])
      if (bad < 0 && (got_pix[i] !== 8'(i % 64) || got_sof[i] !== (i % 64 == 0) ||
                      got_last[i] !== (i % 64 == 63)))
        bad = i;
    tests++;
    if (bad >= 0) begin
      fails++; $display("FAIL cont_pixels: idx %0d pix=%h sof=%b, want %h %b", bad,
                        got_pix[bad], got_sof[bad], 8'(bad % 64), bad % 64 == 0);
    end
    foreach (issued[i])
      if (abad < 0 && issued[i] !== 19'h00100 + 19'(16 * (i % 4))) abad = i;
    tests++;
    if (issued.size() !== 12 || abad >= 0) begin
      fails++; $display("FAIL cont_addr_wrap: %0d issues, first bad %0d, want 12 wrapping", issued.size(), abad);
    end
    tests++;
    if (busy_low || busy !== 1'b1) begin
      fails++; $display("FAIL cont_busy: dropped=%b now=%b, want 0 1", busy_low, busy);
    end
    enable = 1'b0;
    clear_log();
    collect(500, 100, 1, to);
    tests++;
    if (to || got_pix.size() !== 64 || busy !== 1'b0) begin
      fails++; $display("FAIL cont_enable_drop: %0d pixels busy=%b, want 64 0", got_pix.size(), busy);
    end
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL cont_stay_idle: busy=%b, want 0", busy); end
    $display("[TB] continuous: 3 frames plus tail frame");
  endtask

  task automatic test_abort();
    bit to;
    bit found = 0;
    int bad = -1;
    clear_log();
    enable = 1'b0;
    pulse_start();
    pixel_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (pixel_valid && pixel === 8'h25) begin
        found = 1;
        frame_start = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!found) begin fails++; $display("FAIL abort_reach: pixel 25 not seen, want seen"); end
    tick();
    frame_start = 1'b0;
    tests++;
    if (pixel_valid !== 1'b0) begin fails++; $display("FAIL abort_gap1: valid=%b, want 0", pixel_valid); end
    tick();
    tests++;
    if (pixel_valid !== 1'b0) begin fails++; $display("FAIL abort_gap2: valid=%b, want 0", pixel_valid); end
    collect(400, 100, 1, to);
    foreach (got_pix[i])
      if (bad < 0 && (got_pix[i] !== 8'(i) || got_sof[i] !== (i == 0))) bad = i;
    tests++;
    if (to || got_pix.size() !== 64 || bad >= 0) begin
      fails++; $display("FAIL abort_restart: %0d pixels first bad idx %0d, want 64 in order from 00", got_pix.size(), bad);
    end
    $display("[TB] abort: restarted with %0d pixels", got_pix.size());
  endtask

  task automatic test_reset_midframe();
    bit to;
    int active = 0;
    clear_log();
    pixel_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    tests++;
    if (address_b !== 19'h00100 || pixel !== 8'h00 || pixel_valid !== 1'b0 ||
        pixel_sof !== 1'b0 || pixel_last !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_values: addr=%h pix=%h v=%b busy=%b, want 00100 00 0 0",
               address_b, pixel, pixel_valid, busy);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (address_b !== 19'h00100 || busy || pixel_valid) active++;
    end
    tests++;
    if (active !== 0) begin fails++; $display("FAIL midreset_no_reads: %0d active cycles, want 0", active); end
    pulse_start();
    collect(400, 100, 1, to);
    tests++;
    if (to || got_pix.size() !== 64 || got_pix[0] !== 8'h00 || got_pix[63] !== 8'h3F) begin
      fails++; $display("FAIL midreset_recover: %0d pixels, want 64 from 00 to 3f", got_pix.size());
    end
    $display("[TB] reset mid-frame: recovered");
  endtask

  task automatic test_boundary();
    logic [7:0]  pix[$];
    bit          sof[$], lst[$];
    logic [18:0] adr[$];
    logic [18:0] prev;
    int          oob = 0;
    int          bad = -1;
    bit          done = 0;
    frame_start_hi = 1'b1;
    tick();
    frame_start_hi = 1'b0;
    ready_hi = 1'b1;
    prev = address_b_hi;
    for (int c = 0; c < 400 && !done; c++) begin
      if (valid_hi) begin
        pix.push_back(pixel_hi);
        sof.push_back(sof_hi);
        lst.push_back(last_hi);
        if (last_hi) done = 1;
      end
      tick();
      if (address_b_hi < 19'h7FFC0) oob++;
      if (address_b_hi !== prev) begin
        adr.push_back(prev);
        prev = address_b_hi;
      end
    end
    foreach (pix[i])
      if (bad < 0 && (pix[i] !== 8'hC0 + 8'(i) || sof[i] !== (i == 0) || lst[i] !== (i == 63))) bad = i;
    tests++;
    if (!done || pix.size() !== 64 || bad >= 0) begin
      fails++; $display("FAIL boundary_pixels: %0d pixels first bad %0d, want 64 c0..ff", pix.size(), bad);
    end
    tests++;
    if (adr.size() !== 4 || adr[0] !== 19'h7FFC0 || adr[3] !== 19'h7FFF0 || oob !== 0) begin
      fails++;
      $display("FAIL boundary_addr: %0d issues last=%h oob=%0d, want 4 7fff0 0",
               adr.size(), adr.size() > 0 ? adr[adr.size()-1] : 19'h0, oob);
    end
    tests++;
    if (busy_hi !== 1'b0) begin fails++; $display("FAIL boundary_busy: busy=%b, want 0", busy_hi); end
    $display("[TB] boundary: %0d pixels, %0d issues", pix.size(), adr.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_continuous();
    test_abort();
    test_reset_midframe();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
